// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port RAM with
//            a synchronous, 1-cycle-latency read. Each granted access runs
//            IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one state per clock.
// Ports    : Clk, Rst (sync, active-high)
//            Req_x/We_x/Addr_x/WData_x  requester x (A or B) access request
//            Gnt_x, Done_x              ownership and completion pulse
//            RData                      read data, valid with Done
//            Busy                       arbiter not idle
//            Mem_Addr/Mem_Write/M_W_Data/M_R_Data  RAM port
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req_A,
    input  logic              Req_B,
    input  logic              We_A,
    input  logic              We_B,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    input  logic [DATA_W-1:0] WData_A,
    input  logic [DATA_W-1:0] WData_B,
    output logic              Gnt_A,
    output logic              Gnt_B,
    output logic              Done_A,
    output logic              Done_B,
    output logic [DATA_W-1:0] RData,
    output logic              Busy,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] M_W_Data,
    input  logic [DATA_W-1:0] M_R_Data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_prio;   // 0 = A holds priority, 1 = B
    logic   r_owner;  // requester being served: 0 = A, 1 = B
    logic   r_we;     // latched direction of the access in flight

    // Winner selection: on contention the priority holder wins, otherwise
    // whichever requester is asking.
    logic              w_pick_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_pick_b    = (Req_A && Req_B) ? r_prio : Req_B;
    assign w_sel_we    = w_pick_b ? We_B    : We_A;
    assign w_sel_addr  = w_pick_b ? Addr_B  : Addr_A;
    assign w_sel_wdata = w_pick_b ? WData_B : WData_A;

    // All outputs are registered and updated together with the state so each
    // output reflects the state it is in during that cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            Gnt_A     <= 1'b0;
            Gnt_B     <= 1'b0;
            Done_A    <= 1'b0;
            Done_B    <= 1'b0;
            RData     <= '0;
            Busy      <= 1'b0;
            Mem_Addr  <= '0;
            Mem_Write <= 1'b0;
            M_W_Data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Req_A || Req_B) begin
                        r_state   <= S_ISSUE;
                        r_owner   <= w_pick_b;
                        r_we      <= w_sel_we;
                        Gnt_A     <= ~w_pick_b;
                        Gnt_B     <= w_pick_b;
                        Busy      <= 1'b1;
                        // The address register doubles as the latched address
                        // for the rest of the access.
                        Mem_Addr  <= w_sel_addr;
                        Mem_Write <= w_sel_we;
                        M_W_Data  <= w_sel_we ? w_sel_wdata : '0;
                    end
                end
                S_ISSUE: begin
                    // RAM captured the command at this edge; read data is
                    // presented during WAIT.
                    r_state   <= S_WAIT;
                    Mem_Write <= 1'b0;
                    M_W_Data  <= '0;
                end
                S_WAIT: begin
                    r_state  <= S_DONE;
                    if (!r_we) begin
                        RData <= M_R_Data;
                    end
                    Done_A   <= ~r_owner;
                    Done_B   <= r_owner;
                    Mem_Addr <= '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_prio  <= ~r_owner;
                    Gnt_A   <= 1'b0;
                    Gnt_B   <= 1'b0;
                    Done_A  <= 1'b0;
                    Done_B  <= 1'b0;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ADDR_W, 6, word address width, matching Mem_Addr[7:2].
- DATA_W, 32, RAM data width.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- Clk  in  1  single clock; all state changes on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req_A / Req_B  in  1  access request, level; held until the matching Done.
- We_A / We_B  in  1  1 = write, 0 = read; valid while Req is high.
- Addr_A / Addr_B  in  ADDR_W  word address.
- WData_A / WData_B  in  DATA_W  write data.
- Gnt_A / Gnt_B  out  1  requester owns the RAM (ISSUE, WAIT, DONE).
- Done_A / Done_B  out  1  one-cycle completion pulse.
- RData  out  DATA_W  read data; valid while Done is high.
- Busy  out  1  state is not IDLE.
- Mem_Addr  out  ADDR_W  to RAM addra.
- Mem_Write  out  1  to RAM wea.
- M_W_Data  out  DATA_W  to RAM dina.
- M_R_Data  in  DATA_W  from RAM douta; synchronous read, 1-cycle latency.

REQ-003 Clocking and reset SHALL be as decided: one clock, Clk; reset Rst is synchronous and active-high.

Function
REQ-004 The FSM SHALL have four states, IDLE -> ISSUE -> WAIT -> DONE -> IDLE, and SHALL advance one state per clock outside IDLE.
REQ-005 In IDLE, when at least one Req is high at a clock edge, the block SHALL select a winner, latch its We, Addr and WData, and enter ISSUE.
REQ-006 Arbitration SHALL be round-robin:
- pointer Prio, reset value A;
- if both requesters are high, the Prio holder wins;
- if only one is high, that one wins.
REQ-007 On leaving DONE, Prio SHALL be set to the requester that was not served.
REQ-008 In ISSUE:
- Mem_Addr SHALL equal the latched address;
- Mem_Write SHALL equal the latched We;
- M_W_Data SHALL equal the latched WData for writes, and 0 otherwise.
REQ-009 In WAIT:
- Mem_Addr SHALL hold the latched address;
- Mem_Write SHALL be 0;
- M_R_Data is valid in this state.
REQ-010 On the edge leaving WAIT, the block SHALL register M_R_Data into RData for reads; for writes, RData SHALL hold its previous value.
REQ-011 In DONE, the winner's Done SHALL be high for exactly one cycle.
REQ-012 In IDLE:
- Mem_Addr, Mem_Write and M_W_Data SHALL be 0;
- Gnt_A, Gnt_B, Done_A, Done_B and Busy SHALL be 0.
REQ-013 Gnt SHALL be one-hot or zero; Gnt_A and Gnt_B SHALL never be high together.
REQ-014 Latency from the Req-sampling edge to Done high SHALL be 3 cycles.
REQ-015 The minimum transaction period SHALL be 4 cycles.
REQ-016 A requester SHALL deassert Req by the edge that ends DONE; a Req still high in the following IDLE cycle is treated as a new request.
REQ-017 If Req drops during ISSUE or WAIT, the transaction SHALL complete and Done SHALL still pulse.
REQ-018 Changes to Addr, WData or We after the grant SHALL be ignored.
REQ-019 A request from the losing requester SHALL wait in IDLE and be served next, so no requester waits more than one transaction.
REQ-020 Addresses 0 and 63 SHALL be legal; there is no address wrap or offset.

Reset
REQ-021 When Rst is high at an edge, the block SHALL set:
- state IDLE;
- Prio = A;
- RData = 0;
- all outputs to their IDLE values.
REQ-022 Rst SHALL take priority over every transition, including a Req arriving in the same cycle.
REQ-023 If Rst is high during ISSUE of a write, the RAM write at that edge is committed; no Done SHALL be issued.
REQ-024 After Rst deasserts, the first request SHALL be accepted on the next edge.

Verification
REQ-025 Write then read on A:
- stimulus: A writes 0x0000_0DB0 to address 5, then reads address 5;
- required: RData = 0x0000_0DB0 while Done_A is high, 3 cycles after Req is sampled.
REQ-026 Simultaneous requests after reset:
- stimulus: Req_A and Req_B rise together; A writes 0x0000_000F to address 1, B writes 0x003C_C381 to address 2;
- required: A is served first, B is granted in the IDLE that follows; reads back 0x0000_000F and 0x003C_C381.
REQ-027 Held contention:
- stimulus: both requesters held for 4 transactions;
- required: grants alternate A, B, A, B; Gnt_A and Gnt_B are never both high.
REQ-028 Address boundaries:
- stimulus: write 0xFFFF_FFFF to address 63 and 0x0 to address 0, then read both;
- required: each address returns its own value.
REQ-029 Reset mid-operation:
- stimulus: Rst asserted during WAIT of a read;
- required: no Done pulse; state IDLE; RData = 0; next request A wins.
REQ-030 Early Req drop:
- stimulus: Req_B drops in ISSUE;
- required: Done_B still pulses once; Mem_Write is high for exactly 1 cycle on writes.
